// File: rtl/generator_if.sv
// DAC pin bundle: serial data, chip select, clear and SPI clock.
// The generator drives it through the master modport; a board model or bench observes it through slave.
interface generator_if;
  logic spi_mosi;
  logic dac_cs;
  logic dac_clr;
  logic spi_sck;

  modport master (output spi_mosi, output dac_cs, output dac_clr, output spi_sck);
  modport slave  (input  spi_mosi, input  dac_cs, input  dac_clr, input  spi_sck);
endinterface

// File: rtl/generator.sv
// Free-running sawtooth generator that streams one 32-bit LTC2624-style write frame per sample.
// All state changes happen on sck ticks, which occur every CLK_DIV clk cycles.
module generator #(
  parameter int          CLK_DIV = 1,
  parameter logic [11:0] STEP    = 12'd1,
  parameter logic [3:0]  CMD     = 4'b0011,
  parameter logic [3:0]  ADDR    = 4'b1111,
  parameter int          GAP     = 2
) (
  input  logic     clk,
  input  logic     rst,
  generator_if.master dac
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  typedef struct packed {
    logic [7:0]  pad;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic [3:0]  tail;
  } frame_t;

  state_t         state_q;
  logic [11:0]    sample_q;
  logic [31:0]    sh_q;
  logic [5:0]     bcnt_q;
  logic [GW-1:0]  gap_q;
  logic [DW-1:0]  div_q;
  logic           cs_q, sck_q, mosi_q, clr_q;
  logic           tick;
  frame_t         frame_d;

  assign frame_d = '{pad: 8'h00, cmd: CMD, addr: ADDR, data: sample_q, tail: 4'h0};
  // Tick on the first edge after reset so the frame starts immediately.
  assign tick    = (div_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      sh_q     <= '0;
      bcnt_q   <= '0;
      gap_q    <= '0;
      div_q    <= '0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      clr_q <= 1'b1;
      div_q <= (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (gap_q == '0) begin
              cs_q    <= 1'b0;
              // Bit 31 goes out now; the register holds the rest pre-aligned to the MSB.
              mosi_q  <= frame_d[31];
              sh_q    <= {frame_d[30:0], 1'b0};
              bcnt_q  <= '0;
              state_q <= SHIFT;
            end else begin
              gap_q <= gap_q - GW'(1);
            end
          end
          SHIFT: begin
            if (!sck_q) begin
              sck_q  <= 1'b1;
              bcnt_q <= bcnt_q + 6'd1;
            end else if (bcnt_q == 6'd32) begin
              sck_q   <= 1'b0;
              mosi_q  <= 1'b0;
              state_q <= FINISH;
            end else begin
              sck_q  <= 1'b0;
              mosi_q <= sh_q[31];
              sh_q   <= {sh_q[30:0], 1'b0};
            end
          end
          FINISH: begin
            cs_q     <= 1'b1;
            sample_q <= sample_q + STEP;
            gap_q    <= GW'(GAP);
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dac.spi_mosi = mosi_q;
  assign dac.dac_cs   = cs_q;
  assign dac.dac_clr  = clr_q;
  assign dac.spi_sck  = sck_q;
endmodule

// File: tb/tb_generator.sv
// Bench for the ramp DAC generator: four parameter variants share one clock and reset,
// frames are captured on rising sck and compared with an arithmetic model of the ramp.
module tb_generator;
  localparam int ND = 4;
  localparam int CDS[ND] = '{1, 3, 1, 2};
  localparam int STS[ND] = '{1, 1, 2048, 1237};
  localparam int GPS[ND] = '{2, 2, 2, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ND-1:0] mosi_w, cs_w, clr_w, sck_w;

  for (genvar g = 0; g < ND; g++) begin : G
    generator_if bus();
    generator #(.CLK_DIV(CDS[g]), .STEP(12'(STS[g])), .CMD(4'b0011), .ADDR(4'b1111), .GAP(GPS[g]))
      dut (.clk(clk), .rst(rst), .dac(bus));
    assign mosi_w[g] = bus.spi_mosi;
    assign cs_w[g]   = bus.dac_cs;
    assign clr_w[g]  = bus.dac_clr;
    assign sck_w[g]  = bus.spi_sck;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Frame monitor: cyc counts posedges since reset release.
  int          cyc = 0;
  int          nfr[ND];
  logic [31:0] word[ND][16];
  int          st[ND][16];
  int          rs[ND][16];
  int          perr[ND];
  int          rcnt[ND];
  logic [31:0] shr[ND];
  logic [ND-1:0] pcs, psck, pmosi;

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst) begin
        nfr[d]  <= 0;
        perr[d] <= 0;
        rcnt[d] <= 0;
        shr[d]  <= '0;
      end else begin
        if (pcs[d] && !cs_w[d] && nfr[d] < 16) begin
          st[d][nfr[d]] <= cyc + 1;
          rcnt[d] <= 0;
          shr[d]  <= '0;
        end
        if (!cs_w[d] && !psck[d] && sck_w[d]) begin
          rcnt[d] <= rcnt[d] + 1;
          shr[d]  <= {shr[d][30:0], mosi_w[d]};
        end
        if (!pcs[d] && cs_w[d] && nfr[d] < 16) begin
          word[d][nfr[d]] <= shr[d];
          rs[d][nfr[d]]   <= rcnt[d];
          nfr[d] <= nfr[d] + 1;
        end
        perr[d] <= perr[d]
                 + int'((cs_w[d] != pcs[d]) && (sck_w[d] || psck[d]))
                 + int'(cs_w[d] && sck_w[d])
                 + int'((mosi_w[d] != pmosi[d]) && sck_w[d]);
      end
    end
    pcs   <= cs_w;
    psck  <= sck_w;
    pmosi <= mosi_w;
    cyc   <= rst ? cyc + 1 : 0;
  end

  // Reference: frame k of variant d starts at edge 1+k*period and carries k*STEP mod 4096.
  task automatic verify_run(input int run, input string tag);
    for (int d = 0; d < ND; d++) begin
      int p, n;
      p = (66 + GPS[d]) * CDS[d];
      n = 0;
      while (n < 16 && 1 + n * p + 65 * CDS[d] <= run) n++;
      chk($sformatf("%s nframes d%0d", tag, d), nfr[d], n);
      for (int k = 0; k < n && k < nfr[d]; k++) begin
        chk($sformatf("%s word d%0d k%0d", tag, d, k), word[d][k],
            {8'h00, 4'h3, 4'hF, 12'(k * STS[d]), 4'h0});
        chk($sformatf("%s start d%0d k%0d", tag, d, k), st[d][k], 1 + k * p);
        chk($sformatf("%s rises d%0d k%0d", tag, d, k), rs[d][k], 32);
      end
      chk($sformatf("%s protocol d%0d", tag, d), perr[d], 0);
    end
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, " cs"},   cs_w,   4'hF);
    chk({tag, " sck"},  sck_w,  4'h0);
    chk({tag, " mosi"}, mosi_w, 4'h0);
    chk({tag, " clr"},  clr_w,  4'h0);
  endtask

  typedef struct {
    int          d;
    int          k;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 32'h003F0000};
    tbl[1] = '{0, 1, 32'h003F0010};
    tbl[2] = '{0, 2, 32'h003F0020};
    tbl[3] = '{1, 0, 32'h003F0000};
    tbl[4] = '{1, 1, 32'h003F0010};
    tbl[5] = '{2, 0, 32'h003F0000};
    tbl[6] = '{2, 1, 32'h003F8000};
    tbl[7] = '{2, 2, 32'h003F0000};
    tbl[8] = '{3, 1, 32'h003F4D50};
    tbl[9] = '{3, 4, 32'h003F3540};

    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("reset hold", {cs_w, sck_w, mosi_w, clr_w}, {4'hF, 4'h0, 4'h0, 4'h0});
    end

    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("edge1 clr", clr_w, 4'hF);
    chk("edge1 cs",  cs_w,  4'h0);
    chk("edge1 sck", sck_w, 4'h0);
    @(posedge clk); #1;
    chk("edge2 sck", sck_w, 4'b0101);
    for (int e = 3; e <= 7; e++) begin
      @(posedge clk); #1;
      chk($sformatf("div3 sck edge%0d", e), sck_w[1], (e >= 4 && e < 7) ? 1 : 0);
    end
    repeat (23) @(posedge clk);
    #2 async_reset_check("midframe rst");
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;

    repeat (700) @(posedge clk);
    @(negedge clk); #1;
    verify_run(700, "run0");
    foreach (tbl[i])
      chk($sformatf("tbl%0d d%0d k%0d", i, tbl[i].d, tbl[i].k), word[tbl[i].d][tbl[i].k], tbl[i].exp);

    for (int it = 1; it <= 3; it++) begin
      int at, hold;
      at   = $urandom_range(20, 400);
      hold = $urandom_range(1, 6);
      repeat (at) @(posedge clk);
      #2 async_reset_check($sformatf("rand rst%0d", it));
      repeat (hold) @(negedge clk);
      #2 rst = 1'b1;
      repeat (500) @(posedge clk);
      @(negedge clk); #1;
      verify_run(500, $sformatf("run%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/generator.md
Name: generator

Overview:
- Free-running ramp (sawtooth) waveform generator that streams 12-bit samples to an external serial DAC (LTC2624-style, 32-bit frames) over a write-only SPI link.
- Top-level leaf block: its outputs go directly to the board's DAC pins.
- Each frame carries one sample written to all DAC channels. The sample then advances by STEP, wrapping modulo 4096.

Parameters:
- CLK_DIV, 1: spi_sck half-period, in clk cycles. Must be ≥1. One "tick" = CLK_DIV clk cycles.
- STEP, 1: ramp increment per frame, 12-bit, unsigned.
- CMD, 4'b0011: DAC command nibble ("write and update").
- ADDR, 4'b1111: DAC address nibble (all channels).
- GAP, 2: idle ticks with dac_cs high between frames. Must be ≥1.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- spi_mosi, output, 1: serial data to the DAC, MSB first.
- dac_cs, output, 1: DAC chip select, active-low.
- dac_clr, output, 1: DAC asynchronous clear, active-low.
- spi_sck, output, 1: SPI clock. Idles low; the DAC samples on its rising edge.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-low.
- While rst=0, all registers clear immediately:
  - dac_cs=1, spi_sck=0, spi_mosi=0, dac_clr=0.
  - sample=0, state=IDLE.
- Frame word (32 bits, sent MSB first):
  - [31:24] = 8'h00
  - [23:20] = CMD
  - [19:16] = ADDR
  - [15:4] = sample
  - [3:0] = 4'h0
- dac_clr is registered 1 from the first clk edge after reset release, and stays 1 until the next reset.
- FSM states: IDLE, SHIFT, FINISH. State changes happen only on tick boundaries.
- Timing, given for CLK_DIV=1, GAP=2, with edge 1 = the first rising clk edge with rst=1:
  - Edge 1 (IDLE→SHIFT): dac_cs<=0; load the shift register with the frame; spi_mosi<=bit31.
  - SHIFT: spi_sck toggles every tick.
    - Rising sck at edges 2,4,…,64: exactly 32 rising edges.
    - On each falling sck at edges 3,…,63: spi_mosi<=next bit (bit30…bit0).
    - spi_mosi is stable for one full sck period around each rising edge.
  - Edge 65: spi_sck<=0 (final fall); spi_mosi<=0; SHIFT→FINISH.
  - Edge 66: dac_cs<=1; sample<=sample+STEP (mod 4096); FINISH→IDLE; load the gap counter.
  - IDLE holds dac_cs=1 and spi_sck=0 for GAP ticks (edges 67–68). The next frame starts with dac_cs<=0 at edge 69.
  - Frame period = 68 clk cycles for the default parameters.
  - General period = (66 + GAP) × CLK_DIV cycles.
- spi_sck is never high while dac_cs is high. dac_cs changes only while spi_sck=0.
- Bit counter: 6 bits. The frame ends after the 32nd rising sck, with no extra clocks.
- Sample wrap-around: 4095+1 → 0. With general STEP, sample is the 12-bit truncated sum.
- The sample is latched into the shift register at frame start. The value sent is unaffected by the increment later in the same frame.
- Reset mid-frame aborts the frame instantly:
  - dac_cs=1, sck=0, dac_clr=0.
  - After release the ramp restarts at 0, frame 1 at edge 1.
- No inputs other than clk/rst. The generator runs continuously.

Test Plan:
- Reset hold (rst=0, several clk edges) → dac_cs=1, spi_sck=0, spi_mosi=0, dac_clr=0 throughout. Async check: asserting rst between clk edges forces these values without waiting for an edge.
- Release reset → dac_clr=1 at edge 1; dac_cs falls at edge 1; first spi_sck rise at edge 2. Frame 1 captured on rising sck = 32'h003F0000 (sample 0).
- Frame 2 capture → 32'h003F0010 (sample 1). dac_cs low to low spacing = 68 clk cycles. Exactly 32 sck rises per dac_cs-low window.
- Protocol check over ≥3 frames → spi_mosi changes only while spi_sck=0 (or at frame start), and never while sck is high.
- Protocol check over the same frames → dac_cs never changes while spi_sck=1, and spi_sck=0 whenever dac_cs=1.
- Wrap: force or preload sample=4095 (or use STEP=2048 over 2 frames) → data field goes 4095 → 0, or 0 → 2048 → 0 for STEP=2048.
- Mid-frame reset (assert rst at edge 30, release 4 cycles later) → dac_cs=1 and sck=0 immediately. The next frame carries sample 0 and starts at the first edge after release.
- CLK_DIV=3 → sck high/low phases are 3 clk each. Frame period = 68×3 = 204 cycles. Captured data is identical to the CLK_DIV=1 case.
